// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the traffic-light controller and its timing companion.
//   light_t         : light codes driven by the controller (11 is illegal)
//   RED_T/AMBER_T/GREEN_T : per-light durations in ticks used by the controller
//   COUNT_W_DEFAULT : default width of the elapsed-seconds count
package traffic_pkg;

  typedef enum logic [1:0] {
    RED     = 2'b00,
    AMBER   = 2'b01,
    GREEN   = 2'b10,
    ILLEGAL = 2'b11
  } light_t;

  localparam int RED_T   = 8;
  localparam int AMBER_T = 3;
  localparam int GREEN_T = 6;

  localparam int COUNT_W_DEFAULT = 4;

endpackage

// File: rtl/light_timer_if.sv
// light_timer_if
// Signals exchanged between the traffic-light controller and light_timer.
//   state_in   : current light code (controller -> timer)
//   ped_active : pedestrian sequence running (controller -> timer)
//   tick       : one-cycle 1 Hz enable (timer -> controller)
//   count      : whole ticks elapsed in the current light (timer -> controller)
//   ped_req    : tick-aligned pedestrian request (timer -> controller)
// Modports: master = controller side, slave = light_timer side.
interface light_timer_if
  import traffic_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT
);

  light_t             state_in;
  logic               ped_active;
  logic               tick;
  logic [COUNT_W-1:0] count;
  logic               ped_req;

  modport master (
    output state_in,
    output ped_active,
    input  tick,
    input  count,
    input  ped_req
  );

  modport slave (
    input  state_in,
    input  ped_active,
    output tick,
    output count,
    output ped_req
  );

endinterface

// File: rtl/ped_debounce.sv
// ped_debounce
// Conditions the raw pedestrian push-button into a clean accepted level.
//   clk    : system clock
//   reset  : asynchronous, active-high
//   button : raw asynchronous push-button input
//   level  : accepted (debounced) button level
module ped_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_level;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser, then a run-length counter of cycles in which the
  // synchronised level disagrees with the accepted one. Any agreement restarts
  // the run, so only an uninterrupted DEBOUNCE_CYCLES run flips the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
    end else begin
      sync_meta  <= button;
      sync_level <= sync_meta;
      if (sync_level == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/light_timer.sv
// light_timer
// Timing and input-conditioning companion to the traffic-light controller.
//   clk        : system clock
//   reset      : asynchronous, active-high; clears every register
//   ped_button : raw pedestrian push-button, active-high
//   bus        : light_timer_if slave (state_in, ped_active in;
//                tick, count, ped_req out)
module light_timer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int COUNT_W         = COUNT_W_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ped_button,
  light_timer_if.slave  bus
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

  logic [PRESC_W-1:0] presc;
  logic               tick_q;
  light_t             state_q;
  logic [COUNT_W-1:0] count_q;
  logic               ped_level;
  logic               ped_level_q;
  logic               pending;
  logic               ped_req_q;
  logic               ped_rise;

  ped_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ped_debounce (
    .clk    (clk),
    .reset  (reset),
    .button (ped_button),
    .level  (ped_level)
  );

  assign ped_rise = ped_level & ~ped_level_q;

  // Free-running prescaler; tick is registered from the wrap so it lands in
  // the cycle after the wrap and the period stays exactly TICK_DIV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (presc == PRESC_LAST);
      presc  <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
    end
  end

  // A light change clears the count and wins over a coincident tick, so the
  // count restarts from the cycle the new light is first seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RED;
      count_q <= '0;
    end else begin
      state_q <= bus.state_in;
      if (bus.state_in != state_q) begin
        count_q <= '0;
      end else if (tick_q && (count_q != COUNT_MAX)) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  // A request is held until the controller has sampled it on one tick, then
  // dropped together with pending. Presses while the controller is already
  // serving pedestrians or a request is outstanding are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_level_q <= 1'b0;
      pending     <= 1'b0;
      ped_req_q   <= 1'b0;
    end else begin
      ped_level_q <= ped_level;
      if (tick_q && ped_req_q) begin
        pending   <= 1'b0;
        ped_req_q <= 1'b0;
      end else begin
        if (ped_rise && !bus.ped_active && !ped_req_q) begin
          pending <= 1'b1;
        end
        ped_req_q <= pending;
      end
    end
  end

  assign bus.tick    = tick_q;
  assign bus.count   = count_q;
  assign bus.ped_req = ped_req_q;

endmodule

// File: tb/tb_light_timer.sv
// tb_light_timer
// Directed bench for light_timer with TICK_DIV=10 and DEBOUNCE_CYCLES=4.
// Cycle k is the period following the k-th rising clk edge after reset
// release; inputs change and outputs are sampled 1 time unit after each edge.
module tb_light_timer;
  import traffic_pkg::*;

  logic clk;
  logic reset;
  logic ped_button;

  int checksPassed;
  int checksTotal;
  int cyc;
  int reqSamples;
  bit seenReq;

  light_timer_if #(.COUNT_W(4)) bus ();

  light_timer #(
    .TICK_DIV        (10),
    .DEBOUNCE_CYCLES (4),
    .COUNT_W         (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ped_button (ped_button),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  // Advances n cycles, tracking what the controller would sample on ticks.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.tick && bus.ped_req) reqSamples++;
      if (bus.ped_req) seenReq = 1'b1;
    end
  endtask

  task automatic stepTo(input int k);
    if (k > cyc) stepCycles(k - cyc);
  endtask

  task automatic applyStimulus(input logic button, input logic active,
                               input light_t state);
    ped_button     = button;
    bus.ped_active = active;
    bus.state_in   = state;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, RED);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    cyc        = 0;
    reqSamples = 0;
    seenReq    = 1'b0;
  endtask

  initial begin
    checksPassed = 0;
    checksTotal  = 0;
    cyc          = 0;
    reqSamples   = 0;
    seenReq      = 1'b0;

    // Reset state and tick period / count saturation
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, RED);
    #12;
    checkOutput("reset_tick", bus.tick, 0);
    checkOutput("reset_count", bus.count, 0);
    checkOutput("reset_ped_req", bus.ped_req, 0);
    applyReset();
    for (int k = 1; k <= 31; k++) begin
      stepCycles(1);
      checkOutput($sformatf("tick_c%0d", k), bus.tick, (k % 10) == 0);
      if ((k % 10) == 1) checkOutput($sformatf("count_c%0d", k), bus.count, k / 10);
    end
    stepTo(151);
    checkOutput("count_reach_15", bus.count, 15);
    stepTo(200);
    checkOutput("tick_20th", bus.tick, 1);
    checkOutput("count_at_20th", bus.count, 15);
    stepTo(201);
    checkOutput("count_saturated", bus.count, 15);

    // Light change clears count; illegal code treated like any other
    applyReset();
    stepTo(80);
    checkOutput("count_7", bus.count, 7);
    checkOutput("tick_c80", bus.tick, 1);
    stepTo(81);
    bus.state_in = GREEN;
    stepTo(82);
    checkOutput("count_clr_green", bus.count, 0);
    stepTo(90);
    checkOutput("count_hold_0", bus.count, 0);
    stepTo(91);
    checkOutput("count_after_tick", bus.count, 1);
    bus.state_in = ILLEGAL;
    stepTo(92);
    checkOutput("count_clr_into_11", bus.count, 0);
    stepTo(101);
    checkOutput("count_in_11", bus.count, 1);
    bus.state_in = RED;
    stepTo(102);
    checkOutput("count_clr_outof_11", bus.count, 0);

    // Short glitches are rejected
    applyReset();
    for (int len = 1; len <= 3; len++) begin
      ped_button = 1'b1;
      stepCycles(len);
      ped_button = 1'b0;
      stepCycles(10);
    end
    checkOutput("glitch_no_req", seenReq, 0);

    // Clean press: one request, held through the next tick, then cleared
    applyReset();
    stepTo(3);
    ped_button = 1'b1;
    stepTo(10);
    checkOutput("press_req_before", bus.ped_req, 0);
    stepTo(11);
    checkOutput("press_req_rise", bus.ped_req, 1);
    stepTo(20);
    checkOutput("press_req_at_tick", bus.ped_req, 1);
    checkOutput("press_tick_c20", bus.tick, 1);
    stepTo(21);
    checkOutput("press_req_clear", bus.ped_req, 0);
    stepTo(23);
    ped_button = 1'b0;
    stepTo(45);
    checkOutput("press_one_sample", reqSamples, 1);
    checkOutput("press_req_idle", bus.ped_req, 0);

    // Press during pedestrian sequence is dropped; later press is delivered
    applyReset();
    bus.ped_active = 1'b1;
    stepTo(3);
    ped_button = 1'b1;
    stepTo(23);
    ped_button = 1'b0;
    stepTo(40);
    checkOutput("active_dropped", seenReq, 0);
    bus.ped_active = 1'b0;
    stepTo(41);
    ped_button = 1'b1;
    stepTo(49);
    checkOutput("active_after_req", bus.ped_req, 1);
    stepTo(50);
    checkOutput("active_after_tick", bus.tick, 1);
    checkOutput("active_after_req_tick", bus.ped_req, 1);
    stepTo(51);
    checkOutput("active_after_clear", bus.ped_req, 0);
    stepTo(61);
    ped_button = 1'b0;
    stepTo(75);
    checkOutput("active_one_sample", reqSamples, 1);

    // Accepted edge coincides with tick: delivered on the following tick
    applyReset();
    stepTo(14);
    ped_button = 1'b1;
    stepTo(20);
    checkOutput("coinc_tick_c20", bus.tick, 1);
    checkOutput("coinc_req_c20", bus.ped_req, 0);
    stepTo(22);
    checkOutput("coinc_req_rise", bus.ped_req, 1);
    stepTo(30);
    checkOutput("coinc_req_at_tick", bus.ped_req, 1);
    checkOutput("coinc_tick_c30", bus.tick, 1);
    stepTo(31);
    checkOutput("coinc_req_clear", bus.ped_req, 0);
    stepTo(34);
    ped_button = 1'b0;
    stepTo(45);
    checkOutput("coinc_one_sample", reqSamples, 1);

    // Reset mid-request clears everything and restarts the prescaler
    applyReset();
    stepTo(46);
    ped_button = 1'b1;
    stepTo(55);
    checkOutput("mid_count_5", bus.count, 5);
    checkOutput("mid_req_high", bus.ped_req, 1);
    reset      = 1'b1;
    ped_button = 1'b0;
    #1;
    checkOutput("mid_rst_req", bus.ped_req, 0);
    checkOutput("mid_rst_count", bus.count, 0);
    checkOutput("mid_rst_tick", bus.tick, 0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    cyc        = 0;
    reqSamples = 0;
    seenReq    = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      stepCycles(1);
      checkOutput($sformatf("mid_tick_c%0d", k), bus.tick, k == 10);
    end
    stepTo(25);
    checkOutput("mid_req_lost", seenReq, 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
